mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
// - Two-client arbiter upstream of memory; merges cpu (client 0) and a second master (client 1, e.g. DMA) onto one request port.
// - Round-robin grant, one outstanding transaction, response steered back to the owning client.
// - Holds all grants until the host shared-buffer address is valid (buffer_addr_valid from memory).
// PARAMETERS
// - ADDR_W  64   byte address width of a request
// - DATA_W  512  cache-line data width (read and write)
// - CNT_W   16   width of per-client saturating grant counters
// PORTS
// - clk               in   1       single clock; all state on posedge
// - rst               in   1       asynchronous, active-high reset
// - buffer_addr_valid in   1       host buffer address programmed; gates grants
// - cN_req_valid      in   1       client N (N=0,1) request pending; held until cN_req_ready
// - cN_req_we         in   1       1=write, 0=read
// - cN_req_addr       in   ADDR_W  request address
// - cN_req_wdata      in   DATA_W  write data (ignored for reads)
// - cN_req_ready      out  1       combinational; request accepted this cycle
// - cN_rsp_valid      out  1       registered one-cycle response pulse
// - cN_rsp_rdata      out  DATA_W  read data; valid with cN_rsp_valid, 0 on writes
// - mem_req_valid     out  1       request to memory
// - mem_req_we        out  1       latched we
// - mem_req_addr      out  ADDR_W  latched address
// - mem_req_wdata     out  DATA_W  latched write data
// - mem_req_ready     in   1       memory accepts request
// - mem_rsp_valid     in   1       memory completion (read data or write ack)
// - mem_rsp_rdata     in   DATA_W  read data
// - cN_grant_cnt      out  CNT_W   saturating count of accepted client-N requests
// - spurious_rsp      out  1       sticky: mem_rsp_valid seen outside WAIT
// BEHAVIOUR
// - Reset: FSM=IDLE, rr pointer=0 (client 0 favoured), owner=0; all outputs 0; latched req fields 0.
// - States: IDLE -> ISSUE -> WAIT -> IDLE.
// - IDLE: if buffer_addr_valid && any cN_req_valid: pick winner (both valid -> client==rr; one valid -> that one).
//   Assert winner's cN_req_ready same cycle; latch we/addr/wdata and owner; ++cN_grant_cnt (sticks at all-ones); go ISSUE.
//   buffer_addr_valid=0 -> no ready, stay IDLE regardless of requests.
// - ISSUE: mem_req_valid=1 with latched fields, stable until mem_req_ready; on mem_req_ready go WAIT (mem_req_valid drops next cycle).
// - WAIT: mem_req_valid=0; on mem_rsp_valid: next cycle c[owner]_rsp_valid=1 for exactly one cycle;
//   rdata=mem_rsp_rdata if read, 0 if write. rr <= ~owner; go IDLE.
// - Min latency: accept at T, mem_req_valid at T+1, mem_req_ready at T+1 -> WAIT T+2; rsp at T+2 -> client pulse T+3; next accept T+3.
// - The rsp-pulse cycle is IDLE, so a new grant can coincide with a response pulse; legal and required.
// - mem_rsp_valid in IDLE or ISSUE: dropped (no client pulse), spurious_rsp <= 1 until reset.
// - buffer_addr_valid falling mid-transaction: no effect on ISSUE/WAIT; blocks only later grants.
// - Reset mid-transaction: immediate return to reset state; outstanding request abandoned; late rsp sets spurious_rsp.
// - Non-winning client keeps valid high; ready only on a later IDLE grant. No request reordering or buffering beyond one.
// - Counters not cleared by grant activity; only rst clears.
// TESTING
// - buffer_addr_valid=0, c0 read 0x40 held 10 cycles -> no c0_req_ready, mem_req_valid=0; raise -> ready same cycle, mem_req_valid next, addr=0x40.
// - c0,c1 valid together from reset, mem ready/rsp immediate -> grants c0,c1,c0,c1; counts 2/2 after 4 txns; never 2 grants in a row to one client.
// - c1 write 0x80 wdata=0xA5.., mem_req_ready held low 5 cycles -> fields stable 5 cycles; rsp -> c1_rsp_valid 1 cycle, c1_rsp_rdata=0.
// - c0 read, mem_rsp_rdata=0xDEAD_BEEF -> c0_rsp_valid 1 cycle later with that data; c1_rsp_valid stays 0.
// - mem_rsp_valid pulsed in IDLE -> no client rsp, spurious_rsp=1 and sticky; rst clears it to 0.
// - rst asserted in WAIT -> outputs 0 asynchronously; post-reset rsp ignored, spurious_rsp=1; next request served normally (c0 first).

Source files
------------

// File: rtl/mem_arbiter.sv
// Purpose: round-robin arbiter merging two memory clients onto one request port, one transaction in flight.
// Latency: ready is combinational in IDLE; mem_req_valid one cycle after accept; client response one cycle after mem_rsp_valid.
// Backpressure: mem_req_ready low holds ISSUE with stable fields; clients wait unready until the next IDLE grant.
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              buffer_addr_valid,
  // client 0
  input  logic              c0_req_valid,
  input  logic              c0_req_we,
  input  logic [ADDR_W-1:0] c0_req_addr,
  input  logic [DATA_W-1:0] c0_req_wdata,
  output logic              c0_req_ready,
  output logic              c0_rsp_valid,
  output logic [DATA_W-1:0] c0_rsp_rdata,
  // client 1
  input  logic              c1_req_valid,
  input  logic              c1_req_we,
  input  logic [ADDR_W-1:0] c1_req_addr,
  input  logic [DATA_W-1:0] c1_req_wdata,
  output logic              c1_req_ready,
  output logic              c1_rsp_valid,
  output logic [DATA_W-1:0] c1_rsp_rdata,
  // memory side
  output logic              mem_req_valid,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  // status
  output logic [CNT_W-1:0]  c0_grant_cnt,
  output logic [CNT_W-1:0]  c1_grant_cnt,
  output logic              spurious_rsp
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_grant;
  logic                w_win;
  logic                w_rsp_take;
  logic                r_rr;
  logic                r_owner;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_c0_rsp_vld;
  logic                r_c1_rsp_vld;
  logic [DATA_W-1:0]   r_c0_rsp_rdata;
  logic [DATA_W-1:0]   r_c1_rsp_rdata;
  logic [CNT_W-1:0]    r_c0_cnt;
  logic [CNT_W-1:0]    r_c1_cnt;
  logic                r_spurious;

  // Completion is only meaningful while a request is outstanding.
  assign w_rsp_take = (r_state == ST_WAIT) && mem_rsp_valid;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, winner selection, ready and request-valid generation.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant       = 1'b0;
    c0_req_ready  = 1'b0;
    c1_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    // With both pending the rr pointer decides; otherwise the only requester wins.
    w_win = (c0_req_valid && c1_req_valid) ? r_rr : c1_req_valid;
    case (r_state)
      ST_IDLE: begin
        // Ready is masked during reset so every output reads 0 while rst is high.
        if (buffer_addr_valid && (c0_req_valid || c1_req_valid) && !rst) begin
          w_grant      = 1'b1;
          c0_req_ready = ~w_win;
          c1_req_ready = w_win;
          w_state_nxt  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rsp_valid) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch the winning request and owner; advance rr past the owner on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= 1'b0;
      r_rr    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= w_win;
        r_we    <= w_win ? c1_req_we    : c0_req_we;
        r_addr  <= w_win ? c1_req_addr  : c0_req_addr;
        r_wdata <= w_win ? c1_req_wdata : c0_req_wdata;
      end
      if (w_rsp_take) r_rr <= ~r_owner;
    end
  end

  // One-cycle response pulse to the owner; write acks carry zero data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c0_rsp_vld   <= 1'b0;
      r_c1_rsp_vld   <= 1'b0;
      r_c0_rsp_rdata <= '0;
      r_c1_rsp_rdata <= '0;
    end else begin
      r_c0_rsp_vld   <= w_rsp_take && !r_owner;
      r_c1_rsp_vld   <= w_rsp_take &&  r_owner;
      r_c0_rsp_rdata <= (w_rsp_take && !r_owner && !r_we) ? mem_rsp_rdata : '0;
      r_c1_rsp_rdata <= (w_rsp_take &&  r_owner && !r_we) ? mem_rsp_rdata : '0;
    end
  end

  // Saturating per-client grant counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c0_cnt <= '0;
      r_c1_cnt <= '0;
    end else begin
      if (w_grant && !w_win && (r_c0_cnt != {CNT_W{1'b1}})) r_c0_cnt <= r_c0_cnt + CNT_W'(1);
      if (w_grant &&  w_win && (r_c1_cnt != {CNT_W{1'b1}})) r_c1_cnt <= r_c1_cnt + CNT_W'(1);
    end
  end

  // Sticky flag for completions arriving with nothing outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     r_spurious <= 1'b0;
    else if (mem_rsp_valid && r_state != ST_WAIT) r_spurious <= 1'b1;
  end

  assign mem_req_we    = r_we;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;
  assign c0_rsp_valid  = r_c0_rsp_vld;
  assign c1_rsp_valid  = r_c1_rsp_vld;
  assign c0_rsp_rdata  = r_c0_rsp_rdata;
  assign c1_rsp_rdata  = r_c1_rsp_rdata;
  assign c0_grant_cnt  = r_c0_cnt;
  assign c1_grant_cnt  = r_c1_cnt;
  assign spurious_rsp  = r_spurious;

endmodule
